// File: rtl/mux_4_1_rr_select_if.sv
// Handshake bundle between the four sources, the round-robin arbiter and the
// downstream consumer of mux_4_1's output.
interface mux_4_1_rr_select_if;
  logic [3:0] req;
  logic [3:0] last;
  logic       out_ready;
  logic [1:0] sel;
  logic       out_valid;
  logic [3:0] ack;
  logic       busy;

  modport master (
    input  req, last, out_ready,
    output sel, out_valid, ack, busy
  );

  modport slave (
    output req, last, out_ready,
    input  sel, out_valid, ack, busy
  );
endinterface

// File: rtl/mux_4_1_rr_select.sv
// Round-robin burst arbiter driving mux_4_1's select; holds sel for a whole
// burst and re-arbitrates back-to-back on release or abort.
module mux_4_1_rr_select #(
  parameter  int MAX_BURST = 4,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_4_1_rr_select_if.master  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       out_valid, xfer, rel;
  logic [3:0] ack, masked;

  // First set bit of mask searching start, start+1, ... with wrap.
  function automatic logic [1:0] rr_pick(input logic [1:0] start, input logic [3:0] mask);
    logic [1:0] idx;
    rr_pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    out_valid = 1'b0;
    xfer      = 1'b0;
    rel       = 1'b0;
    ack       = 4'b0;
    masked    = bus.req & ~(4'b1 << sel_q);
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          sel_d   = rr_pick(ptr_q, bus.req);
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        out_valid = bus.req[sel_q];
        xfer      = out_valid & bus.out_ready;
        ack       = xfer ? (4'b1 << sel_q) : 4'b0;
        if (xfer) cnt_d = cnt_q + CNT_W'(1);
        // Release after a completed burst, or abort when the source drops req.
        rel = (xfer & (bus.last[sel_q] | (cnt_q == CNT_W'(MAX_BURST - 1)))) | ~bus.req[sel_q];
        if (rel) begin
          ptr_d = sel_q + 2'd1;
          if (|masked) begin
            sel_d = rr_pick(sel_q + 2'd1, masked);
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q == GRANT);
  assign bus.out_valid = out_valid;
  assign bus.ack       = ack;

endmodule
